// File: rtl/i2c_slave.sv
// I2C slave with a 7-bit address: receives write bytes into Rx_data and returns Tx_data on reads.
// SCL and SDA_in are oversampled on clk through synchronizers; every bus decision uses the synchronized copies.
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       SCL,
  input  logic       SDA_in,
  output logic       SDA_out,
  input  logic [7:0] Tx_data,
  output logic [7:0] Rx_data,
  output logic       rx_valid,
  output logic       tx_req,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR      = 4'd1,
    ST_ADDR_ACK  = 4'd2,
    ST_WRITE     = 4'd3,
    ST_WRITE_ACK = 4'd4,
    ST_READ      = 4'd5,
    ST_READ_ACK  = 4'd6
  } state_e;

  // Synchronizer chains: meta -> sync, plus prev for edge detection.
  logic scl_meta_q, scl_sync_q, scl_prev_q;
  logic sda_meta_q, sda_sync_q, sda_prev_q;

  state_e     state_q,    state_d;
  logic [2:0] bit_cnt_q,  bit_cnt_d;
  logic [7:0] shift_q,    shift_d;
  logic       sda_out_q,  sda_out_d;
  logic [7:0] rx_data_q,  rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       tx_req_q,   tx_req_d;
  logic       rw_q,       rw_d;
  logic       phase_q,    phase_d;

  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] byte_in;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      // NOTE: non-blocking assignments keep each flop reading the previous value of its neighbour,
      // which is what makes this a real two-stage synchronizer rather than one wire.
      scl_meta_q <= 1'b1;
      scl_sync_q <= 1'b1;
      scl_prev_q <= 1'b1;
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_meta_q <= SCL;
      scl_sync_q <= scl_meta_q;
      scl_prev_q <= scl_sync_q;
      sda_meta_q <= SDA_in;
      sda_sync_q <= sda_meta_q;
      sda_prev_q <= sda_sync_q;
    end
  end

  assign scl_rise  = scl_sync_q & ~scl_prev_q;
  assign scl_fall  = ~scl_sync_q & scl_prev_q;
  assign start_det = scl_sync_q & scl_prev_q & sda_prev_q & ~sda_sync_q;
  assign stop_det  = scl_sync_q & scl_prev_q & ~sda_prev_q & sda_sync_q;
  assign byte_in   = {shift_q[6:0], sda_sync_q};

  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the case leaves one unassigned (no latches).
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    sda_out_d  = sda_out_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_req_d   = 1'b0;
    rw_d       = rw_q;
    phase_d    = phase_q;

    if (start_det) begin
      state_d   = ST_ADDR;
      bit_cnt_d = 3'd0;
      sda_out_d = 1'b1;
      phase_d   = 1'b0;
    end else if (stop_det) begin
      state_d   = ST_IDLE;
      bit_cnt_d = 3'd0;
      sda_out_d = 1'b1;
      phase_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: ;

        ST_ADDR: begin
          if (scl_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (byte_in[7:1] == SLAVE_ADDR) begin
                state_d = ST_ADDR_ACK;
                rw_d    = byte_in[0];
                phase_d = 1'b0;
              end else begin
                state_d = ST_IDLE;
              end
            end
          end
        end

        // phase_q=0: waiting for the fall that starts the ACK; phase_q=1: ACK is on the bus.
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            if (!phase_q) begin
              sda_out_d = 1'b0;
              phase_d   = 1'b1;
            end else begin
              phase_d   = 1'b0;
              bit_cnt_d = 3'd0;
              if (rw_q) begin
                state_d   = ST_READ;
                shift_d   = Tx_data;
                sda_out_d = Tx_data[7];
                tx_req_d  = 1'b1;
              end else begin
                state_d   = ST_WRITE;
                sda_out_d = 1'b1;
              end
            end
          end
        end

        ST_WRITE: begin
          if (scl_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              rx_data_d  = byte_in;
              rx_valid_d = 1'b1;
              state_d    = ST_WRITE_ACK;
              phase_d    = 1'b0;
            end
          end
        end

        ST_WRITE_ACK: begin
          if (scl_fall) begin
            if (!phase_q) begin
              sda_out_d = 1'b0;
              phase_d   = 1'b1;
            end else begin
              sda_out_d = 1'b1;
              phase_d   = 1'b0;
              state_d   = ST_WRITE;
            end
          end
        end

        // The MSB is already on the bus on entry; each fall shifts out the next bit.
        ST_READ: begin
          if (scl_fall) begin
            if (bit_cnt_q == 3'd7) begin
              sda_out_d = 1'b1;
              bit_cnt_d = 3'd0;
              state_d   = ST_READ_ACK;
              phase_d   = 1'b0;
            end else begin
              sda_out_d = shift_q[6];
              shift_d   = {shift_q[6:0], 1'b0};
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end
        end

        ST_READ_ACK: begin
          if (scl_rise) begin
            if (sda_sync_q) state_d = ST_IDLE;
            else            phase_d = 1'b1;
          end else if (scl_fall && phase_q) begin
            phase_d   = 1'b0;
            bit_cnt_d = 3'd0;
            shift_d   = Tx_data;
            sda_out_d = Tx_data[7];
            tx_req_d  = 1'b1;
            state_d   = ST_READ;
          end
        end

        default: begin
          state_d   = ST_IDLE;
          sda_out_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'h00;
      sda_out_q  <= 1'b1;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
      rw_q       <= 1'b0;
      phase_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      sda_out_q  <= sda_out_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_req_q   <= tx_req_d;
      rw_q       <= rw_d;
      phase_q    <= phase_d;
    end
  end

  assign SDA_out  = sda_out_q;
  assign Rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign tx_req   = tx_req_q;
  assign state    = state_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: a bus-master model on a wired-AND SDA line, with scoreboard queues
// for received bytes and read-back bits.
module tb_i2c_slave;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       sda_out;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_req;
  logic [3:0] state;
  logic       sda_line;

  int n_checks = 0;
  int n_err    = 0;
  int rx_cnt   = 0;
  int tx_cnt   = 0;
  int low_cnt  = 0;

  logic [7:0] exp_rx[$];
  logic       exp_bits[$];

  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_ADDR = 4'd1;
  localparam logic [3:0] S_READ = 4'd5;

  assign sda_line = sda_m & sda_out;

  i2c_slave #(.SLAVE_ADDR(7'h50)) dut (
    .clk     (clk),
    .nrst    (nrst),
    .SCL     (scl),
    .SDA_in  (sda_line),
    .SDA_out (sda_out),
    .Tx_data (tx_data),
    .Rx_data (rx_data),
    .rx_valid(rx_valid),
    .tx_req  (tx_req),
    .state   (state)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "bench did not finish");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Per-cycle monitor, run from the stimulus process at every falling clk edge.
  task automatic sample();
    if (rx_valid) begin
      rx_cnt++;
      if (exp_rx.size() == 0) check("rx_unexpected_pulse", 32'(rx_valid), 32'd0);
      else                    check("rx_data", 32'(rx_data), 32'(exp_rx.pop_front()));
    end
    if (tx_req) tx_cnt++;
    if (sda_out === 1'b0) low_cnt++;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      sample();
    end
  endtask

  task automatic push_bits(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) exp_bits.push_back(b[i]);
  endtask

  // Leaves SCL low; works from idle (both high) and as a repeated START.
  task automatic bus_start();
    tick(5); sda_m = 1'b1;
    tick(5); scl = 1'b1;
    tick(5); sda_m = 1'b0;
    tick(3); check("start_to_addr", 32'(state), 32'(S_ADDR));
    tick(2); scl = 1'b0;
  endtask

  task automatic bus_stop();
    tick(5); sda_m = 1'b0;
    tick(5); scl = 1'b1;
    tick(5); sda_m = 1'b1;
    tick(3); check("stop_to_idle", 32'(state), 32'(S_IDLE));
    tick(7);
  endtask

  task automatic send_bit(input logic b);
    tick(5); sda_m = b;
    tick(5); scl = 1'b1;
    tick(10); scl = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] b, input logic exp_ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    tick(5); sda_m = 1'b1;
    tick(5); scl = 1'b1;
    tick(5); check("ack_bit", 32'(sda_out), 32'(exp_ack));
    tick(5); scl = 1'b0;
  endtask

  // Clocks 8 bits from the slave, loads the next Tx_data, then gives ACK (nack=0) or NACK.
  task automatic read_byte(input logic nack, input logic [7:0] next_tx);
    for (int i = 0; i < 8; i++) begin
      tick(5); sda_m = 1'b1;
      tick(5); scl = 1'b1;
      tick(5);
      check("tx_bit_queue_nonempty", 32'(exp_bits.size() > 0), 32'd1);
      if (exp_bits.size() > 0) check("tx_bit", 32'(sda_line), 32'(exp_bits.pop_front()));
      tick(5); scl = 1'b0;
    end
    tx_data = next_tx;
    if (!nack) push_bits(next_tx);
    tick(5); sda_m = nack;
    tick(5); scl = 1'b1;
    tick(10); scl = 1'b0;
    tick(1); sda_m = 1'b1;
  endtask

  initial begin
    // Reset state
    tick(3);
    check("rst_sda_out", 32'(sda_out), 32'd1);
    check("rst_rx_data", 32'(rx_data), 32'h00);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_tx_req", 32'(tx_req), 32'd0);
    check("rst_state", 32'(state), 32'(S_IDLE));
    nrst = 1'b1;
    tick(3);

    // Write 0x3C to address 0x50
    rx_cnt = 0;
    bus_start();
    write_byte(8'hA0, 1'b0);
    exp_rx.push_back(8'h3C);
    write_byte(8'h3C, 1'b0);
    bus_stop();
    check("wr_rx_data", 32'(rx_data), 32'h3C);
    check("wr_rx_pulses", 32'(rx_cnt), 32'd1);

    // Address mismatch: 0x51 is ignored, bus never pulled low
    rx_cnt = 0; tx_cnt = 0; low_cnt = 0;
    bus_start();
    write_byte(8'hA2, 1'b1);
    check("mis_state", 32'(state), 32'(S_IDLE));
    write_byte(8'h55, 1'b1);
    bus_stop();
    check("mis_sda_low_cycles", 32'(low_cnt), 32'd0);
    check("mis_rx_pulses", 32'(rx_cnt), 32'd0);
    check("mis_tx_pulses", 32'(tx_cnt), 32'd0);

    // Read 0xA5 (ACK), then 0x5A (NACK)
    tx_cnt = 0;
    tx_data = 8'hA5;
    push_bits(8'hA5);
    bus_start();
    write_byte(8'hA1, 1'b0);
    tick(4);
    check("rd_state_read", 32'(state), 32'(S_READ));
    check("rd_tx_req_first", 32'(tx_cnt), 32'd1);
    read_byte(1'b0, 8'h5A);
    read_byte(1'b1, 8'h00);
    check("rd_nack_idle", 32'(state), 32'(S_IDLE));
    check("rd_tx_pulses", 32'(tx_cnt), 32'd2);
    bus_stop();

    // Write 0x11, repeated START, read 0xC3
    rx_cnt = 0; tx_cnt = 0;
    bus_start();
    write_byte(8'hA0, 1'b0);
    exp_rx.push_back(8'h11);
    write_byte(8'h11, 1'b0);
    bus_start();
    tx_data = 8'hC3;
    push_bits(8'hC3);
    write_byte(8'hA1, 1'b0);
    tick(4);
    check("rs_state_read", 32'(state), 32'(S_READ));
    read_byte(1'b1, 8'h00);
    bus_stop();
    check("rs_rx_data", 32'(rx_data), 32'h11);
    check("rs_rx_pulses", 32'(rx_cnt), 32'd1);
    check("rs_tx_pulses", 32'(tx_cnt), 32'd1);

    // STOP after 4 bits of a write byte discards it
    rx_cnt = 0;
    bus_start();
    write_byte(8'hA0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    bus_stop();
    check("sp_rx_unchanged", 32'(rx_data), 32'h11);
    check("sp_rx_pulses", 32'(rx_cnt), 32'd0);

    // Reset while the slave drives a 0 during a read
    tx_data = 8'h00;
    bus_start();
    write_byte(8'hA1, 1'b0);
    tick(4);
    check("rr_driving_low", 32'(sda_out), 32'd0);
    nrst = 1'b0;
    #1;
    check("rr_sda_released", 32'(sda_out), 32'd1);
    check("rr_state", 32'(state), 32'(S_IDLE));
    check("rr_rx_data", 32'(rx_data), 32'h00);
    tick(2);
    nrst = 1'b1;
    rx_cnt = 0; tx_cnt = 0; low_cnt = 0;
    write_byte(8'hA0, 1'b1);
    check("rr_ignored_state", 32'(state), 32'(S_IDLE));
    check("rr_ignored_low", 32'(low_cnt), 32'd0);
    check("rr_ignored_rx", 32'(rx_cnt), 32'd0);
    check("rr_ignored_tx", 32'(tx_cnt), 32'd0);
    bus_stop();

    // Fresh transaction after reset
    rx_cnt = 0;
    bus_start();
    write_byte(8'hA0, 1'b0);
    exp_rx.push_back(8'h77);
    write_byte(8'h77, 1'b0);
    bus_stop();
    check("rec_rx_data", 32'(rx_data), 32'h77);
    check("rec_rx_pulses", 32'(rx_cnt), 32'd1);

    check("rx_queue_drained", 32'(exp_rx.size()), 32'd0);
    check("bit_queue_drained", 32'(exp_bits.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/i2c_slave.md
I2C_SLAVE -- requirements
Module: i2c_slave

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'h50, the 7-bit address the block responds to.
REQ-002 SHALL have port clk, input, 1, system clock; all logic on rising edge.
REQ-003 SHALL have port nrst, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have port SCL, input, 1, bus clock driven by the master; asynchronous to clk.
REQ-005 SHALL have port SDA_in, input, 1, sampled bus data line; asynchronous to clk.
REQ-006 SHALL have port SDA_out, output, 1, open-drain intent: 0 pulls SDA low, 1 releases it.
REQ-007 SHALL have port Tx_data, input, 8, byte returned to the master on a read.
REQ-008 SHALL have port Rx_data, output, 8, last byte written by the master.
REQ-009 SHALL have port rx_valid, output, 1, one-clk pulse when Rx_data updates.
REQ-010 SHALL have port tx_req, output, 1, one-clk pulse when Tx_data is latched.
REQ-011 SHALL have port state, output, 4, current FSM state for debug.

Function
REQ-012 SCL and SDA_in SHALL each pass through a 2-flop synchronizer, plus one register for edge detection; all decisions SHALL use the synchronized values only.
REQ-013 Legal bus timing: SCL high and low phases each last at least 4 clk cycles.
REQ-014 START condition: synchronized SDA falls while synchronized SCL is high.
REQ-015 STOP condition: synchronized SDA rises while synchronized SCL is high.
REQ-016 START and STOP SHALL each be detected within 3 clk cycles of the raw edge.
REQ-017 FSM encoding SHALL be IDLE=0, ADDR=1, ADDR_ACK=2, WRITE=3, WRITE_ACK=4, READ=5, READ_ACK=6; state output SHALL equal this encoding.
REQ-018 START in any state SHALL go to ADDR, clear the bit counter and release SDA_out; this covers repeated START.
REQ-019 STOP in any state SHALL go to IDLE and release SDA_out.
REQ-020 START or STOP SHALL take priority over a bit sample or SDA update detected in the same cycle.
REQ-021 Data bits SHALL be sampled on the synchronized SCL rising edge, MSB first.
REQ-022 SDA_out SHALL change only on the synchronized SCL falling edge, except on STOP, START or reset.
REQ-023 ADDR: 8 bits SHALL be shifted in, comprising the address in bits [7:1] and R/W in bit [0] (1 = read).
REQ-024 On address match, ADDR_ACK: SDA_out=0 from the falling edge after bit 8 until the falling edge after the 9th clock.
REQ-025 On address mismatch: go to IDLE, keep SDA_out=1, ignore all traffic until the next START.
REQ-026 After ADDR_ACK with R/W=0: go to WRITE.
REQ-027 In WRITE, on the 8th rising edge: Rx_data SHALL load the byte and rx_valid SHALL pulse for 1 clk.
REQ-028 WRITE_ACK SHALL always drive the ACK (SDA_out=0) for the 9th clock, then return to WRITE for the next byte.
REQ-029 After ADDR_ACK with R/W=1: at the ending falling edge, Tx_data SHALL be latched, tx_req SHALL pulse and the MSB SHALL be driven; enter READ.
REQ-030 In READ, each subsequent falling edge SHALL drive the next bit.
REQ-031 At the falling edge after bit 8 of a READ byte: SDA_out SHALL be released and the FSM SHALL enter READ_ACK.
REQ-032 In READ_ACK, the master's bit SHALL be sampled on the rising edge.
REQ-033 If the READ_ACK sample is 0 (ACK): at the next falling edge, relatch Tx_data, pulse tx_req, drive the MSB and return to READ.
REQ-034 If the READ_ACK sample is 1 (NACK): go to IDLE with SDA_out=1.
REQ-035 A STOP in mid-byte SHALL discard the partial byte, with no rx_valid pulse.
REQ-036 The bit counter SHALL be 3 bits wide and wrap 7->0 on each byte boundary.

Reset
REQ-037 While nrst=0, outputs SHALL be immediately: SDA_out=1, Rx_data=8'h00, rx_valid=0, tx_req=0, state=IDLE(0).
REQ-038 While nrst=0, the shift register, bit counter and synchronizers SHALL be cleared, with the synchronizers set to 1 (idle bus).
REQ-039 Reset mid-transfer SHALL release SDA at once; after release the block SHALL wait for a fresh START.

Verification
REQ-040 Write: START, 0xA0, 0x3C, STOP -> ACK low on both 9th clocks; Rx_data=0x3C; exactly one rx_valid pulse; state ends at 0.
REQ-041 Mismatch: START, 0xA2 (address 0x51) -> SDA_out stays 1 for the whole frame; state=0; no pulses.
REQ-042 Read: Tx_data=0xA5, START, 0xA1 -> SDA carries 1010_0101; master ACK with Tx_data=0x5A -> SDA carries 0101_1010; master NACK -> state=0; 2 tx_req pulses.
REQ-043 Repeated START after write byte 0x11, then 0xA1 read -> rx_valid once (0x11); state passes to ADDR then READ; ACK given.
REQ-044 STOP after 4 bits of a write byte -> state=0 within 3 clk; Rx_data unchanged; no rx_valid.
REQ-045 nrst low during READ while driving 0 -> SDA_out=1 the same cycle; state=0; the following bus traffic is ignored until START.
